lp_tree_deserializer: RTL and testbench

Receive-side counterpart of the low-power tree serializer. Takes the serial bit stream, hunts for a sync word, and acquires frame lock. Once locked, it emits aligned parallel data words with a one-cycle valid strobe. It sits at the RX pad boundary, in the clk_i domain, ahead of the word-level consumer.

---
 rtl/lp_tree_deserializer_pkg.sv | 17 +
 rtl/lp_tree_deserializer_if.sv | 23 ++
 rtl/lp_tree_deserializer_shift.sv | 47 ++++
 rtl/lp_tree_deserializer.sv | 161 ++++++++++++++++
 tb/tb_lp_tree_deserializer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lp_tree_deserializer_pkg.sv
// Shared types and helpers for the low-power tree serdes receive path.
package lp_serdes_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StAcquire,
    StLocked
  } rx_state_e;

  localparam logic [7:0] SyncWordDefault = 8'hB8;

  // Width of a counter that spans slot 0 (sync) through slot frame_words.
  function automatic int unsigned word_cnt_w(input int unsigned frame_words);
    return (frame_words < 1) ? 1 : $clog2(frame_words + 1);
  endfunction

endpackage

// File: rtl/lp_tree_deserializer_if.sv
// Serial-in / word-out bundle of the tree deserializer.
interface lp_tree_deserializer_if #(
  parameter int unsigned Width = 8
);
  logic             din_i;
  logic             en_i;
  logic [Width-1:0] data_o;
  logic             valid_o;
  logic             locked_o;
  logic             sync_err_o;

  // Driver side (pad / stimulus).
  modport master (
    output din_i, en_i,
    input  data_o, valid_o, locked_o, sync_err_o
  );

  // Deserializer side.
  modport slave (
    input  din_i, en_i,
    output data_o, valid_o, locked_o, sync_err_o
  );
endinterface

// File: rtl/lp_tree_deserializer_shift.sv
// Bit shifter with in-word bit counter and word-boundary strobe.
module lp_deser_shift #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             din_i,
  input  logic             count_en_i,
  output logic [Width-1:0] sr_next_o,
  output logic             word_done_o
);

  localparam int unsigned BitCntW = $clog2(Width);
  localparam logic [BitCntW-1:0] BitLast = BitCntW'(Width - 1);

  logic [Width-1:0]   sr_q;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;

  // Comparisons downstream see the word including this cycle's bit.
  assign sr_next_o   = {sr_q[Width-2:0], din_i};
  assign word_done_o = en_i && count_en_i && (bit_cnt_q == BitLast);

  // Bit position only advances while framed; held at 0 while hunting.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (!count_en_i) begin
      bit_cnt_d = '0;
    end else if (en_i) begin
      bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + BitCntW'(1);
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      if (en_i) begin
        sr_q <= sr_next_o;
      end
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/lp_tree_deserializer.sv
// Frame-locking deserializer: hunts for the sync word, acquires lock over
// several frames, then emits aligned data words with a one-cycle strobe.
module lp_tree_deserializer
  import lp_serdes_pkg::*;
#(
  parameter int unsigned     Width      = 8,
  parameter logic [Width-1:0] SyncWord  = Width'(SyncWordDefault),
  parameter int unsigned     FrameWords = 4,
  parameter int unsigned     LockFrames = 2,
  parameter int unsigned     MissLimit  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  lp_tree_deserializer_if.slave bus_io
);

  localparam int unsigned WcW = word_cnt_w(FrameWords);
  localparam int unsigned GcW = $clog2(LockFrames + 1);
  localparam int unsigned McW = $clog2(MissLimit + 1);

  localparam logic [WcW-1:0] WordLast   = WcW'(FrameWords);
  localparam logic [GcW-1:0] GoodTarget = GcW'(LockFrames);
  localparam logic [McW-1:0] MissTarget = McW'(MissLimit);

  rx_state_e        state_q, state_d;
  logic [WcW-1:0]   word_cnt_q, word_cnt_d;
  logic [GcW-1:0]   good_cnt_q, good_cnt_d;
  logic [McW-1:0]   miss_cnt_q, miss_cnt_d;
  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sync_err_q, sync_err_d;

  logic [Width-1:0] sr_next;
  logic             word_done;
  logic             sync_hit;
  logic             sync_slot;
  logic [WcW-1:0]   word_cnt_inc;

  lp_deser_shift #(
    .Width(Width)
  ) u_shift (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (bus_io.en_i),
    .din_i      (bus_io.din_i),
    .count_en_i (state_q != StHunt),
    .sr_next_o  (sr_next),
    .word_done_o(word_done)
  );

  assign sync_hit     = (sr_next == SyncWord);
  assign sync_slot    = (word_cnt_q == '0);
  assign word_cnt_inc = (word_cnt_q == WordLast) ? '0 : word_cnt_q + WcW'(1);

  // Framing FSM: next state, slot counters and output pulses.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;

    unique case (state_q)
      StHunt: begin
        // No word alignment here, so every bit position is a candidate.
        if (bus_io.en_i && sync_hit) begin
          word_cnt_d = WcW'(1);
          good_cnt_d = GcW'(1);
          miss_cnt_d = '0;
          state_d    = (LockFrames <= 1) ? StLocked : StAcquire;
        end
      end

      StAcquire: begin
        if (word_done) begin
          word_cnt_d = word_cnt_inc;
          if (sync_slot) begin
            if (sync_hit) begin
              good_cnt_d = good_cnt_q + GcW'(1);
              if (good_cnt_d == GoodTarget) begin
                state_d    = StLocked;
                miss_cnt_d = '0;
              end
            end else begin
              sync_err_d = 1'b1;
              state_d    = StHunt;
              word_cnt_d = '0;
              good_cnt_d = '0;
              miss_cnt_d = '0;
            end
          end
        end
      end

      StLocked: begin
        if (word_done) begin
          word_cnt_d = word_cnt_inc;
          if (sync_slot) begin
            if (sync_hit) begin
              miss_cnt_d = '0;
            end else begin
              // Flywheel: keep alignment until too many misses in a row.
              sync_err_d = 1'b1;
              miss_cnt_d = miss_cnt_q + McW'(1);
              if (miss_cnt_d == MissTarget) begin
                state_d    = StHunt;
                word_cnt_d = '0;
                good_cnt_d = '0;
                miss_cnt_d = '0;
              end
            end
          end else begin
            data_d  = sr_next;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StHunt;
      end
    endcase
  end

  // Framing state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StHunt;
      word_cnt_q <= '0;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus_io.data_o     = data_q;
  assign bus_io.valid_o    = valid_q;
  assign bus_io.locked_o   = (state_q == StLocked);
  assign bus_io.sync_err_o = sync_err_q;

  // Bit counting is disabled while hunting, so a match never lands on a boundary.
  hunt_no_word_done_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(state_q == StHunt && word_done));

  // A slot is either a sync slot or a data slot, never both.
  pulse_excl_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(valid_q && sync_err_q));

endmodule

// File: tb/tb_lp_tree_deserializer.sv
// Directed scoreboard bench for lp_tree_deserializer (8-bit words, sync B8,
// 4 data words per frame, lock after 2 good syncs, drop after 2 misses).
module tb_lp_tree_deserializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lp_tree_deserializer_if #(.Width(8)) bus ();

  lp_tree_deserializer #(
    .Width     (8),
    .SyncWord  (8'hB8),
    .FrameWords(4),
    .LockFrames(2),
    .MissLimit (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus_io(bus)
  );

  typedef struct {
    logic [7:0] w;
    int         c;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   err_seen = 0;
  int   e0;
  bit   locked_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Monitor: pop the scoreboard whenever a word is presented.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.valid_o) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: got data %0h at cycle %0d, want no output",
                   bus.data_o, cyc);
        end else begin
          e = sb.pop_front();
          if (bus.data_o !== e.w || cyc != e.c) begin
            bad++;
            $display("FAIL word: got %0h at cycle %0d, want %0h at cycle %0d",
                     bus.data_o, cyc, e.w, e.c);
          end
        end
      end
      if (bus.valid_o && bus.sync_err_o) begin
        total++;
        bad++;
        $display("FAIL pulse_overlap: got valid_o=1 sync_err_o=1, want not both");
      end
      if (bus.sync_err_o) err_seen++;
      if (bus.locked_o) locked_seen = 1'b1;
    end
  end

  // One bit with an optional random idle gap before it; en_i drops right after the edge.
  task automatic send_bit(input logic b, input int gap);
    if (gap > 0) repeat ($urandom_range(gap, 1)) @(posedge clk);
    @(negedge clk);
    bus.din_i = b;
    bus.en_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.en_i = 1'b0;
  endtask

  // Output is expected during the cycle after the one that carried the LSB.
  task automatic send_word(input logic [7:0] w, input bit expect_out, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(w[i], gap);
    if (expect_out) sb.push_back('{w: w, c: cyc});
  endtask

  task automatic send_data(input logic [31:0] d, input bit expect_out, input int gap);
    for (int k = 0; k < 4; k++) send_word(d[31-8*k -: 8], expect_out, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    locked_seen = 1'b0;
  endtask

  // Two-frame clean lock then one more frame; data after the second sync is emitted.
  task automatic clean_lock(input int gap);
    for (int i = 0; i < 3; i++) send_bit(1'b0, gap);
    send_word(8'hB8, 1'b0, gap);
    send_data(32'h11223344, 1'b0, gap);
    check("locked_after_frame1", {31'd0, bus.locked_o}, 32'd0);
    send_word(8'hB8, 1'b0, gap);
    check("locked_after_sync2", {31'd0, bus.locked_o}, 32'd1);
    send_data(32'h11223344, 1'b1, gap);
    send_word(8'hB8, 1'b0, gap);
    send_data(32'h11223344, 1'b1, gap);
    idle(3);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.din_i = 1'b0;
    bus.en_i  = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    check("rst_data", bus.data_o, 32'd0);
    check("rst_locked", {31'd0, bus.locked_o}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check("idle_data", bus.data_o, 32'd0);
    check("idle_valid", {31'd0, bus.valid_o}, 32'd0);
    check("idle_locked", {31'd0, bus.locked_o}, 32'd0);
    check("idle_sync_err", {31'd0, bus.sync_err_o}, 32'd0);
    check("idle_no_lock_seen", {31'd0, locked_seen}, 32'd0);

    // Clean lock, contiguous bits.
    e0 = err_seen;
    clean_lock(0);
    check("clean_no_err", err_seen - e0, 32'd0);

    // Same stream with random idle gaps between bits.
    do_reset();
    e0 = err_seen;
    clean_lock(5);
    check("gap_no_err", err_seen - e0, 32'd0);

    // Flywheel: single miss tolerated, two consecutive misses drop lock.
    e0 = err_seen;
    send_word(8'hB9, 1'b0, 0);
    idle(1);
    check("fly_err1", err_seen - e0, 32'd1);
    check("fly_locked_miss1", {31'd0, bus.locked_o}, 32'd1);
    send_data(32'h55667788, 1'b1, 0);
    send_word(8'hB8, 1'b0, 0);
    send_data(32'h99AABBCC, 1'b1, 0);
    send_word(8'hB9, 1'b0, 0);
    check("fly_locked_miss_a", {31'd0, bus.locked_o}, 32'd1);
    send_data(32'hA1A2A3A4, 1'b1, 0);
    send_word(8'hB9, 1'b0, 0);
    check("fly_locked_miss_b", {31'd0, bus.locked_o}, 32'd0);
    send_data(32'h00000000, 1'b0, 0);
    idle(3);
    check("fly_err3", err_seen - e0, 32'd3);
    check("fly_data_hold", bus.data_o, 32'hA4);
    check("fly_sb_drained", sb.size(), 32'd0);

    // False sync during acquisition.
    do_reset();
    e0 = err_seen;
    send_word(8'hB8, 1'b0, 0);
    send_data(32'h11223344, 1'b0, 0);
    send_word(8'h00, 1'b0, 0);
    idle(1);
    check("false_err", err_seen - e0, 32'd1);
    check("false_locked", {31'd0, bus.locked_o}, 32'd0);
    check("false_no_lock_seen", {31'd0, locked_seen}, 32'd0);
    send_word(8'hB8, 1'b0, 0);
    send_data(32'h11223344, 1'b0, 0);
    send_word(8'hB8, 1'b0, 0);
    check("false_relock", {31'd0, bus.locked_o}, 32'd1);
    send_data(32'h11223344, 1'b1, 0);
    idle(3);
    check("false_sb_drained", sb.size(), 32'd0);

    // Async reset in the middle of a locked data word.
    send_word(8'hB8, 1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    check("pre_rst_data", bus.data_o, 32'h44);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", bus.data_o, 32'd0);
    check("arst_locked", {31'd0, bus.locked_o}, 32'd0);
    check("arst_valid", {31'd0, bus.valid_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    locked_seen = 1'b0;
    send_word(8'hB8, 1'b0, 0);
    send_data(32'h11223344, 1'b0, 0);
    check("arst_not_locked_f1", {31'd0, bus.locked_o}, 32'd0);
    send_word(8'hB8, 1'b0, 0);
    check("arst_relock", {31'd0, bus.locked_o}, 32'd1);
    send_data(32'h5A6B7C8D, 1'b1, 0);
    idle(3);
    check("arst_sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
